// File: rtl/stbc_col_encoder_if.sv
// Symbol-in / codeword-out bus of the quasi-Alamouti column encoder.
// The master side produces symbols and consumes codewords.
interface stbc_col_encoder_if #(
  parameter int W    = 16,
  parameter int NROW = 4
);
  logic              flush;
  logic              sym_valid;
  logic              sym_ready;
  logic [W-1:0]      sym_r;
  logic [W-1:0]      sym_i;
  logic              col_valid;
  logic              col_ready;
  logic              start;
  logic [NROW*W-1:0] col0_r;
  logic [NROW*W-1:0] col0_i;
  logic [NROW*W-1:0] col1_r;
  logic [NROW*W-1:0] col1_i;

  modport master (
    output flush, sym_valid, sym_r, sym_i, col_ready,
    input  sym_ready, col_valid, start, col0_r, col0_i, col1_r, col1_i
  );

  modport slave (
    input  flush, sym_valid, sym_r, sym_i, col_ready,
    output sym_ready, col_valid, start, col0_r, col0_i, col1_r, col1_i
  );
endinterface

// File: rtl/stbc_col_encoder.sv
// Groups four Q8.8 symbols into a 4x2 quasi-Alamouti codeword:
// col0 = [s0 s1 s2 s3], col1 = [-s1* s0* -s3* s2*].
module stbc_col_encoder #(
  parameter int W    = 16,
  parameter int NROW = 4
) (
  input logic              clk,
  input logic              rst,
  stbc_col_encoder_if.slave bus
);
  localparam int CW = NROW * W;

  logic [1:0]    cnt;
  logic [W-1:0]  buf_r [3];
  logic [W-1:0]  buf_i [3];
  logic          col_valid;
  logic          start;
  logic [CW-1:0] col0_r, col0_i, col1_r, col1_i;

  logic          in_fire;
  logic          load;
  logic          drain;
  logic [CW-1:0] nxt0_r, nxt0_i, nxt1_r, nxt1_i;

  // Two's complement negation, clamped so the most negative value maps to max positive.
  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] x);
    if (x == {1'b1, {(W-1){1'b0}}})
      return {1'b0, {(W-1){1'b1}}};
    return -x;
  endfunction

  // Slot 3 needs the output register free, or emptying in this same cycle.
  assign bus.sym_ready = !rst && ((cnt != 2'd3) || !col_valid || bus.col_ready);
  assign in_fire       = bus.sym_valid && bus.sym_ready;
  assign load          = in_fire && (cnt == 2'd3) && !bus.flush;
  assign drain         = col_valid && bus.col_ready;

  always_comb begin
    nxt0_r = {bus.sym_r, buf_r[2], buf_r[1], buf_r[0]};
    nxt0_i = {bus.sym_i, buf_i[2], buf_i[1], buf_i[0]};
    nxt1_r = {buf_r[2], neg_sat(bus.sym_r), buf_r[0], neg_sat(buf_r[1])};
    nxt1_i = {neg_sat(buf_i[2]), bus.sym_i, neg_sat(buf_i[0]), buf_i[1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 2'd0;
      for (int k = 0; k < 3; k++) begin
        buf_r[k] <= '0;
        buf_i[k] <= '0;
      end
      col_valid <= 1'b0;
      start     <= 1'b0;
      col0_r    <= '0;
      col0_i    <= '0;
      col1_r    <= '0;
      col1_i    <= '0;
    end else begin
      start <= load;

      if (bus.flush)
        cnt <= 2'd0;
      else if (in_fire)
        cnt <= cnt + 2'd1;

      if (in_fire && !bus.flush) begin
        case (cnt)
          2'd0: begin buf_r[0] <= bus.sym_r; buf_i[0] <= bus.sym_i; end
          2'd1: begin buf_r[1] <= bus.sym_r; buf_i[1] <= bus.sym_i; end
          2'd2: begin buf_r[2] <= bus.sym_r; buf_i[2] <= bus.sym_i; end
          default: ;
        endcase
      end

      // A load overrides a simultaneous drain, keeping col_valid high.
      if (load) begin
        col0_r    <= nxt0_r;
        col0_i    <= nxt0_i;
        col1_r    <= nxt1_r;
        col1_i    <= nxt1_i;
        col_valid <= 1'b1;
      end else if (drain) begin
        col_valid <= 1'b0;
      end
    end
  end

  assign bus.col_valid = col_valid;
  assign bus.start     = start;
  assign bus.col0_r    = col0_r;
  assign bus.col0_i    = col0_i;
  assign bus.col1_r    = col1_r;
  assign bus.col1_i    = col1_i;
endmodule

// File: tb/tb_stbc_col_encoder.sv
// Directed bench for stbc_col_encoder: table of hand-computed codewords plus
// backpressure, streaming, flush and async-reset sequences.
module tb_stbc_col_encoder;
  typedef struct {
    logic [3:0][15:0] sr;
    logic [3:0][15:0] si;
    logic [63:0]      c0r;
    logic [63:0]      c0i;
    logic [63:0]      c1r;
    logic [63:0]      c1i;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t tbl [3];

  stbc_col_encoder_if #(.W(16)) bus ();

  stbc_col_encoder #(.W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] r, input logic [15:0] i);
    bus.sym_valid = v;
    bus.sym_r     = r;
    bus.sym_i     = i;
  endtask

  task automatic feedWord(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, v.sr[k], v.si[k]);
      checkOutput("sym_ready_feed", bus.sym_ready, 1);
      step();
    end
    applyStimulus(1'b0, 16'h0, 16'h0);
  endtask

  task automatic checkWord(input string name, input vec_t v);
    checkOutput({name, "_col0_r"}, bus.col0_r, v.c0r);
    checkOutput({name, "_col0_i"}, bus.col0_i, v.c0i);
    checkOutput({name, "_col1_r"}, bus.col1_r, v.c1r);
    checkOutput({name, "_col1_i"}, bus.col1_i, v.c1i);
  endtask

  task automatic checkZero(input string name);
    checkOutput({name, "_col_valid"}, bus.col_valid, 0);
    checkOutput({name, "_start"}, bus.start, 0);
    checkOutput({name, "_sym_ready"}, bus.sym_ready, 0);
    checkOutput({name, "_col0_r"}, bus.col0_r, 0);
    checkOutput({name, "_col0_i"}, bus.col0_i, 0);
    checkOutput({name, "_col1_r"}, bus.col1_r, 0);
    checkOutput({name, "_col1_i"}, bus.col1_i, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.flush     = 1'b0;
    bus.col_ready = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0);

    // Basic mapping vector
    tbl[0].sr  = {16'h0000, 16'h0080, 16'h0300, 16'h0100};
    tbl[0].si  = {16'h0040, 16'h0000, 16'hFF00, 16'h0200};
    tbl[0].c0r = 64'h0000_0080_0300_0100;
    tbl[0].c0i = 64'h0040_0000_FF00_0200;
    tbl[0].c1r = 64'h0080_0000_0100_FD00;
    tbl[0].c1i = 64'h0000_0040_FE00_FF00;
    // Saturation corners: every negated component is 0x8000
    tbl[1].sr  = {16'h8000, 16'h7FFF, 16'h8000, 16'h1234};
    tbl[1].si  = {16'h7FFF, 16'h8000, 16'h0001, 16'h8000};
    tbl[1].c0r = 64'h8000_7FFF_8000_1234;
    tbl[1].c0i = 64'h7FFF_8000_0001_8000;
    tbl[1].c1r = 64'h7FFF_7FFF_1234_7FFF;
    tbl[1].c1i = 64'h7FFF_7FFF_7FFF_0001;
    // Near-boundary values that must not saturate
    tbl[2].sr  = {16'h0010, 16'h8001, 16'hFFFF, 16'h0001};
    tbl[2].si  = {16'h8001, 16'h0010, 16'h7FFF, 16'hFFFF};
    tbl[2].c0r = 64'h0010_8001_FFFF_0001;
    tbl[2].c0i = 64'h8001_0010_7FFF_FFFF;
    tbl[2].c1r = 64'h8001_FFF0_0001_0001;
    tbl[2].c1i = 64'hFFF0_8001_0001_7FFF;

    #12;
    checkZero("reset_hold");
    rst = 1'b0;
    step();

    // Table-driven mapping checks
    bus.col_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      feedWord(tbl[v]);
      checkOutput($sformatf("vec%0d_col_valid", v), bus.col_valid, 1);
      checkOutput($sformatf("vec%0d_start", v), bus.start, 1);
      checkWord($sformatf("vec%0d", v), tbl[v]);
      step();
      checkOutput($sformatf("vec%0d_drained", v), bus.col_valid, 0);
      checkOutput($sformatf("vec%0d_start_low", v), bus.start, 0);
    end

    // Backpressure: held codeword blocks slot 3 only
    bus.col_ready = 1'b0;
    feedWord(tbl[0]);
    checkOutput("bp_first_start", bus.start, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, tbl[1].sr[k], tbl[1].si[k]);
      checkOutput("bp_ready_slot", bus.sym_ready, 1);
      step();
      checkOutput("bp_hold_valid", bus.col_valid, 1);
      checkOutput("bp_hold_start", bus.start, 0);
      checkOutput("bp_hold_col0_r", bus.col0_r, tbl[0].c0r);
    end
    applyStimulus(1'b1, tbl[1].sr[3], tbl[1].si[3]);
    #1;
    checkOutput("bp_ready_slot3", bus.sym_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("bp_stall_ready", bus.sym_ready, 0);
      checkOutput("bp_stall_start", bus.start, 0);
      checkOutput("bp_stall_col1_i", bus.col1_i, tbl[0].c1i);
    end
    bus.col_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", bus.sym_ready, 1);
    step();
    bus.col_ready = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("bp_reload_valid", bus.col_valid, 1);
    checkOutput("bp_reload_start", bus.start, 1);
    checkWord("bp_reload", tbl[1]);
    step();
    checkOutput("bp_after_start", bus.start, 0);
    checkOutput("bp_after_valid", bus.col_valid, 1);
    bus.col_ready = 1'b1;
    step();
    checkOutput("bp_final_drain", bus.col_valid, 0);

    // Streaming: one codeword every 4 cycles, no bubbles
    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'b1, tbl[(n / 4) % 3].sr[n % 4], tbl[(n / 4) % 3].si[n % 4]);
      checkOutput("stream_ready", bus.sym_ready, 1);
      step();
      checkOutput($sformatf("stream_start_%0d", n), bus.start, ((n % 4) == 3) ? 1 : 0);
      checkOutput($sformatf("stream_valid_%0d", n), bus.col_valid, ((n % 4) == 3) ? 1 : 0);
      if ((n % 4) == 3)
        checkOutput($sformatf("stream_col1_r_%0d", n), bus.col1_r, tbl[(n / 4) % 3].c1r);
    end
    applyStimulus(1'b0, 16'h0, 16'h0);
    step();
    checkOutput("stream_end_valid", bus.col_valid, 0);

    // Flush discards a partial codeword
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 16'hDEAD, 16'hBEEF);
      step();
    end
    applyStimulus(1'b0, 16'h0, 16'h0);
    bus.flush = 1'b1;
    #1;
    checkOutput("flush_ready", bus.sym_ready, 1);
    step();
    bus.flush = 1'b0;
    feedWord(tbl[2]);
    checkOutput("flush_new_start", bus.start, 1);
    checkWord("flush_new", tbl[2]);
    step();

    // Flush coincident with slot 3 wins
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, tbl[0].sr[k], tbl[0].si[k]);
      step();
    end
    applyStimulus(1'b1, tbl[0].sr[3], tbl[0].si[3]);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("flush4_valid", bus.col_valid, 0);
    checkOutput("flush4_start", bus.start, 0);
    step();
    checkOutput("flush4_valid_later", bus.col_valid, 0);
    feedWord(tbl[1]);
    checkOutput("flush4_next_start", bus.start, 1);
    checkWord("flush4_next", tbl[1]);

    // Flush leaves a held codeword alone
    bus.col_ready = 1'b0;
    bus.flush     = 1'b1;
    step();
    bus.flush = 1'b0;
    checkOutput("flush_hold_valid", bus.col_valid, 1);
    checkOutput("flush_hold_col0_i", bus.col0_i, tbl[1].c0i);
    bus.col_ready = 1'b1;
    step();
    checkOutput("flush_hold_drain", bus.col_valid, 0);

    // Async reset mid-hold with a partial codeword pending
    bus.col_ready = 1'b0;
    feedWord(tbl[1]);
    checkOutput("areset_pre_valid", bus.col_valid, 1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 16'h5555, 16'hAAAA);
      step();
    end
    applyStimulus(1'b0, 16'h0, 16'h0);
    #3;
    rst = 1'b1;
    #1;
    checkZero("areset");
    #2;
    rst = 1'b0;
    step();
    checkOutput("areset_post_start", bus.start, 0);
    bus.col_ready = 1'b1;
    feedWord(tbl[2]);
    checkOutput("areset_word_valid", bus.col_valid, 1);
    checkOutput("areset_word_start", bus.start, 1);
    checkWord("areset_word", tbl[2]);
    step();
    checkOutput("areset_word_drain", bus.col_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/stbc_col_encoder.md
Name: stbc_col_encoder

Overview:
- Transmit-side counterpart of the SOML decoder's column-processing path.
- Accepts a stream of complex Q8.8 QAM symbols over a valid/ready handshake and groups them four at a time.
- Builds a 4x2 quasi-Alamouti codeword and presents it as two packed 64-bit complex columns (col0_r/i, col1_r/i), in the same format the decoder datapath consumes.
- Emits a one-cycle start pulse per codeword so a downstream channel model or decoder stage can be triggered directly.

Parameters:
- W, 16, width of one real or imaginary component (two's complement, Q8.8 at default).
- NROW, 4, symbols per column; fixed at 4. Column buses are NROW*W = 64 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards a partially collected codeword.
- sym_valid  in  1  input symbol valid.
- sym_ready  out  1  block can accept a symbol this cycle.
- sym_r  in  W  symbol real part, Q8.8.
- sym_i  in  W  symbol imaginary part, Q8.8.
- col_valid  out  1  codeword columns valid.
- col_ready  in  1  downstream accepts the codeword.
- start  out  1  one-cycle pulse on the first cycle of each new codeword's col_valid.
- col0_r  out  64  column 0, real parts; row k at bits [16k+15:16k].
- col0_i  out  64  column 0, imaginary parts.
- col1_r  out  64  column 1, real parts.
- col1_i  out  64  column 1, imaginary parts.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, collect buffer cleared.
  - col_valid=0, start=0, all col* outputs=0, sym_ready=0 while rst is held.
- Input transfer: occurs when sym_valid && sym_ready. The symbol is written into slot s[cnt]; cnt increments modulo 4.
- sym_ready = (cnt != 3) || !col_valid || col_ready. Slots 0..2 are always accepted. Slot 3 is accepted only if the output register is free or being drained that same cycle.
- Codeword load: on the cycle slot 3 is accepted, the output registers load from s0..s2 plus the live s3 input, and col_valid is set next cycle. Latency is 1 cycle from the 4th symbol handshake to col_valid=1.
- Column mapping, rows 0..3:
  - col0 = [s0, s1, s2, s3]
  - col1 = [-conj(s1), conj(s0), -conj(s3), conj(s2)]
  - In component form, col1 row0 = (-s1_r, +s1_i), row1 = (s0_r, -s0_i), row2 = (-s3_r, +s3_i), row3 = (s2_r, -s2_i).
- Negation saturates: -(-32768) = 32767. No other arithmetic; no width growth.
- Output handshake:
  - col_valid stays 1 with outputs stable until col_ready=1.
  - On a col_ready handshake with no new load in the same cycle, col_valid=0 next cycle. The col* data holds its last value.
  - Drain and load in the same cycle: col_valid stays 1 and the new data appears next cycle.
- start: registered and high for exactly the first cycle of each newly loaded codeword. A back-to-back load (drain+load) produces a fresh pulse. start is never high while col_valid=0.
- flush:
  - cnt=0 next cycle and any partial symbols are discarded.
  - A codeword already held in the output register is unaffected.
  - If flush coincides with a slot-3 transfer, flush wins: nothing is loaded and cnt=0.
  - sym_ready is unaffected by flush.
- Reset asserted mid-codeword or mid-hold: everything clears immediately. The held codeword is lost and no start is issued.
- Throughput: 1 codeword per 4 symbol cycles at sustained sym_valid=1, col_ready=1, with no bubbles.

Test Plan:
- Basic mapping: feed s0=(0x0100,0x0200), s1=(0x0300,0xFF00), s2=(0x0080,0), s3=(0,0x0040), col_ready=1 -> one cycle after the 4th handshake, col_valid=1 and start=1 for 1 cycle, with:
  - col0_r=0x0000_0080_0300_0100
  - col0_i=0x0040_0000_FF00_0200
  - col1_r=0x0080_0000_0100_FD00
  - col1_i=0x0000_0040_FE00_FF00
- Saturation: s1_r=0x8000, s0_i=0x8000 -> col1_r row0=0x7FFF and col1_i row1=0x7FFF.
- Backpressure: col_ready=0 with 8 symbols offered -> 3 more accepted, then sym_ready=0 at cnt=3. Outputs stay stable. Raising col_ready for 1 cycle -> the 4th symbol is accepted in that cycle, new data appears next cycle with a second start pulse.
- Streaming: 16 symbols with continuous valid/ready -> 4 codewords, 4 start pulses, spaced exactly 4 cycles apart, sym_ready constantly 1.
- Flush: 2 symbols, then flush, then 4 new symbols -> the codeword contains only the 4 new symbols. Flush coincident with the 4th symbol -> no col_valid.
- Async reset: assert rst mid-hold (col_valid=1), off-edge -> col_valid, start and col* go to 0 immediately. After release, the first 4 symbols form a correct codeword.
